// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared memory bus.
// The arbiter connects through the master modport: it serves both pipeline
// ports and drives the memory bus. The slave modport is the view of the
// surrounding system: pipeline requesters plus the memory responder.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Instruction fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic              i_stall;

  // Load/store port
  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  // Shared single-port memory bus
  logic              m_req;
  logic              m_we;
  logic [BE_W-1:0]   m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_valid, i_stall,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_rdata, d_valid, d_stall,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_valid, i_stall,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_rdata, d_valid, d_stall,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch (I) and
// load/store (D). One bus transaction is in flight at a time; the response
// is steered back to whichever port owns the transaction. D normally wins
// because it belongs to the older instruction, but a run of D grants while
// fetch is waiting is capped at MAX_D_STREAK so fetch cannot starve.
//
// Transaction timeline (fastest case):
//   edge 0 : request sampled in IDLE, m_* fields registered, m_req rises
//   edge 1 : m_gnt seen in REQ, m_req drops, write fields cleared
//   edge 2 : m_rvalid seen in WAIT, rdata captured, valid pulses
// The valid cycle is spent back in IDLE. The completing port's request is
// still visible in that cycle (it is only dropped afterwards), so it is
// excluded from arbitration there; the other port, if pending, is issued.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
  localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Sequencer state
  state_t              state_r;
  owner_t              owner_r;
  logic [STREAK_W-1:0] streak_r;

  // Registered bus request fields
  logic                m_req_r;
  logic                m_we_r;
  logic [BE_W-1:0]     m_be_r;
  logic [ADDR_W-1:0]   m_addr_r;
  logic [DATA_W-1:0]   m_wdata_r;

  // Registered responses towards the pipeline
  logic [DATA_W-1:0]   i_rdata_r;
  logic                i_valid_r;
  logic [DATA_W-1:0]   d_rdata_r;
  logic                d_valid_r;

  // Arbitration terms
  logic                i_elig_s;
  logic                d_elig_s;
  logic                streak_full_s;
  logic                pick_d_s;
  logic                pick_i_s;
  logic [STREAK_W-1:0] streak_inc_s;

  // Arbitration choice for the IDLE state; a port completing this cycle is not eligible.
  always_comb begin
    i_elig_s      = bus.i_req & ~i_valid_r;
    d_elig_s      = bus.d_req & ~d_valid_r;
    streak_full_s = (streak_r == STREAK_MAX);
    pick_d_s      = d_elig_s & ~(i_elig_s & streak_full_s);
    pick_i_s      = ~pick_d_s & i_elig_s;
    if (streak_full_s) begin
      streak_inc_s = STREAK_MAX;
    end else begin
      streak_inc_s = streak_r + STREAK_ONE;
    end
  end

  // Bus sequencer: owner selection, request fields, response capture and valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWN_I;
      streak_r  <= STREAK_ZERO;
      m_req_r   <= 1'b0;
      m_we_r    <= 1'b0;
      m_be_r    <= {BE_W{1'b0}};
      m_addr_r  <= {ADDR_W{1'b0}};
      m_wdata_r <= {DATA_W{1'b0}};
      i_rdata_r <= {DATA_W{1'b0}};
      i_valid_r <= 1'b0;
      d_rdata_r <= {DATA_W{1'b0}};
      d_valid_r <= 1'b0;
    end else begin
      // Valid strobes are single-cycle unless re-armed below.
      i_valid_r <= 1'b0;
      d_valid_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (pick_d_s) begin
            owner_r   <= OWN_D;
            m_req_r   <= 1'b1;
            m_we_r    <= bus.d_we;
            m_be_r    <= bus.d_be;
            m_addr_r  <= bus.d_addr;
            m_wdata_r <= bus.d_wdata;
            state_r   <= ST_REQ;
            // Only D grants taken while fetch is waiting count towards the cap.
            if (bus.i_req) begin
              streak_r <= streak_inc_s;
            end else begin
              streak_r <= STREAK_ZERO;
            end
          end else if (pick_i_s) begin
            owner_r   <= OWN_I;
            m_req_r   <= 1'b1;
            m_we_r    <= 1'b0;
            m_be_r    <= {BE_W{1'b1}};
            m_addr_r  <= bus.i_addr;
            m_wdata_r <= {DATA_W{1'b0}};
            state_r   <= ST_REQ;
            streak_r  <= STREAK_ZERO;
          end else begin
            // Nothing to issue; a stray m_rvalid here is ignored.
            if (!bus.i_req) begin
              streak_r <= STREAK_ZERO;
            end else begin
              streak_r <= streak_r;
            end
          end
        end

        ST_REQ: begin
          // Request fields stay frozen until the bus accepts them.
          if (bus.m_gnt) begin
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_be_r    <= {BE_W{1'b0}};
            m_wdata_r <= {DATA_W{1'b0}};
            state_r   <= ST_WAIT;
          end else begin
            state_r   <= ST_REQ;
          end
        end

        ST_WAIT: begin
          // Loads and stores both finish on m_rvalid; store data is a don't-care.
          if (bus.m_rvalid) begin
            if (owner_r == OWN_D) begin
              d_rdata_r <= bus.m_rdata;
              d_valid_r <= 1'b1;
            end else begin
              i_rdata_r <= bus.m_rdata;
              i_valid_r <= 1'b1;
            end
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          m_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_r;
  assign bus.m_we    = m_we_r;
  assign bus.m_be    = m_be_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_wdata = m_wdata_r;

  assign bus.i_rdata = i_rdata_r;
  assign bus.i_valid = i_valid_r;
  assign bus.d_rdata = d_rdata_r;
  assign bus.d_valid = d_valid_r;

  // Stalls freeze a stage from request until its completion pulse.
  assign bus.i_stall = bus.i_req & ~i_valid_r;
  assign bus.d_stall = bus.d_req & ~d_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// a randomized phase, all checked every cycle against a transaction-level
// reference model of the sharing rules.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_STREAK = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_D_STREAK(MAX_STREAK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: is the bus owned by a transaction, has the bus accepted
  // it, who owns it, and which port's completion is visible this cycle.
  bit          busy_m;
  bit          accepted_m;
  int          owner_m;       // 0 = fetch, 1 = load/store
  bit          done_i_m;
  bit          done_d_m;
  int          streak_m;
  logic        exp_mreq;
  logic        exp_mwe;
  logic [3:0]  exp_mbe;
  logic [31:0] exp_maddr;
  logic [31:0] exp_mwdata;
  logic [31:0] exp_irdata;
  logic [31:0] exp_drdata;
  bit          awaiting;      // random bus responder owes a response

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_m = 1'b0; accepted_m = 1'b0; owner_m = 0;
    done_i_m = 1'b0; done_d_m = 1'b0; streak_m = 0;
    exp_mreq = 1'b0; exp_mwe = 1'b0; exp_mbe = 4'h0;
    exp_maddr = 32'h0; exp_mwdata = 32'h0;
    exp_irdata = 32'h0; exp_drdata = 32'h0;
  endtask

  // Advance the model across one rising edge, using the inputs applied for it.
  task automatic model_edge();
    bit ni, nd, ie, de;
    ni = 1'b0; nd = 1'b0;
    if (busy_m && accepted_m) begin
      if (bus.m_rvalid) begin
        busy_m = 1'b0; accepted_m = 1'b0;
        if (owner_m == 1) begin nd = 1'b1; exp_drdata = bus.m_rdata; end
        else begin ni = 1'b1; exp_irdata = bus.m_rdata; end
      end
    end else if (busy_m) begin
      if (bus.m_gnt) begin
        accepted_m = 1'b1;
        exp_mreq = 1'b0; exp_mwe = 1'b0; exp_mbe = 4'h0; exp_mwdata = 32'h0;
      end
    end else begin
      ie = bus.i_req && !done_i_m;
      de = bus.d_req && !done_d_m;
      if (de && !(ie && streak_m == MAX_STREAK)) begin
        busy_m = 1'b1; owner_m = 1; exp_mreq = 1'b1;
        exp_mwe = bus.d_we; exp_mbe = bus.d_be;
        exp_maddr = bus.d_addr; exp_mwdata = bus.d_wdata;
        if (bus.i_req) streak_m = (streak_m < MAX_STREAK) ? streak_m + 1 : MAX_STREAK;
        else streak_m = 0;
      end else if (ie) begin
        busy_m = 1'b1; owner_m = 0; exp_mreq = 1'b1;
        exp_mwe = 1'b0; exp_mbe = 4'hF;
        exp_maddr = bus.i_addr; exp_mwdata = 32'h0;
        streak_m = 0;
      end else if (!bus.i_req) begin
        streak_m = 0;
      end
    end
    done_i_m = ni; done_d_m = nd;
  endtask

  task automatic check();
    chk("m_req",   32'(bus.m_req),   32'(exp_mreq));
    chk("m_we",    32'(bus.m_we),    32'(exp_mwe));
    chk("m_be",    32'(bus.m_be),    32'(exp_mbe));
    chk("m_addr",  bus.m_addr,       exp_maddr);
    chk("m_wdata", bus.m_wdata,      exp_mwdata);
    chk("i_valid", 32'(bus.i_valid), 32'(done_i_m));
    chk("d_valid", 32'(bus.d_valid), 32'(done_d_m));
    chk("i_rdata", bus.i_rdata,      exp_irdata);
    chk("d_rdata", bus.d_rdata,      exp_drdata);
    chk("i_stall", 32'(bus.i_stall), 32'(bus.i_req && !done_i_m));
    chk("d_stall", 32'(bus.d_stall), 32'(bus.d_req && !done_d_m));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check();
  endtask

  // Bus grants after gd idle cycles, then answers with rd on the next cycle.
  task automatic serve(input int gd, input logic [31:0] rd);
    repeat (gd) step();
    bus.m_gnt = 1'b1;
    step();
    bus.m_gnt = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata = rd;
    step();
    bus.m_rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check();
    @(posedge clk);
    #1;
    check();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
    awaiting = 1'b0;
    model_reset();
    #2;

    // 1: fetch held through reset, issued one cycle after release
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
    apply_reset();
    step();
    chk("t1_mreq", 32'(bus.m_req), 32'd1);
    chk("t1_maddr", bus.m_addr, 32'h0000_1000);
    chk("t1_mbe", 32'(bus.m_be), 32'hF);
    serve(0, 32'h0000_0013);
    chk("t1_ivalid", 32'(bus.i_valid), 32'd1);
    chk("t1_irdata", bus.i_rdata, 32'h0000_0013);
    bus.i_req = 1'b0;
    step();
    chk("t1_ivalid_pulse", 32'(bus.i_valid), 32'd0);

    // 2: simultaneous requests, load first, fetch right after d_valid
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0080;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h0000_0100;
    step();
    chk("t2_d_first", bus.m_addr, 32'h0000_0100);
    serve(1, 32'hA5A5_0001);
    chk("t2_dvalid", 32'(bus.d_valid), 32'd1);
    chk("t2_istall", 32'(bus.i_stall), 32'd1);
    bus.d_req = 1'b0;
    step();
    chk("t2_i_next", bus.m_addr, 32'h0000_0080);
    chk("t2_i_mreq", 32'(bus.m_req), 32'd1);
    serve(0, 32'h1234_5678);
    chk("t2_irdata", bus.i_rdata, 32'h1234_5678);
    chk("t2_drdata_hold", bus.d_rdata, 32'hA5A5_0001);
    bus.i_req = 1'b0;
    step();

    // 3: fetch held, load/store re-requested at every completion
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_2000;
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_0300;
    step();
    for (int r = 0; r < 4; r++) begin
      chk("t3_d_addr", bus.m_addr, 32'h0000_0300 + 32'(r * 4));
      serve(0, $urandom);
      bus.d_addr = 32'h0000_0300 + 32'((r + 1) * 4);
      step();
      chk("t3_i_addr", bus.m_addr, 32'h0000_2000 + 32'(r * 4));
      serve(0, $urandom);
      bus.i_addr = 32'h0000_2000 + 32'((r + 1) * 4);
      step();
    end
    serve(0, $urandom);
    bus.d_req = 1'b0;
    step();
    serve(0, $urandom);
    bus.i_req = 1'b0;
    step();

    // 4: store with a slow grant
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
    bus.d_addr = 32'h0000_0040; bus.d_wdata = 32'hDEAD_BEEF;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t4_mwe", 32'(bus.m_we), 32'd1);
      chk("t4_mbe", 32'(bus.m_be), 32'h3);
      chk("t4_mwdata", bus.m_wdata, 32'hDEAD_BEEF);
      step();
    end
    serve(0, 32'h0000_0000);
    chk("t4_dvalid", 32'(bus.d_valid), 32'd1);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    step();

    // 5: reset while waiting for the response, then a stray response
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_0500;
    step();
    bus.m_gnt = 1'b1;
    step();
    bus.m_gnt = 1'b0;
    bus.d_req = 1'b0;
    apply_reset();
    chk("t5_mreq", 32'(bus.m_req), 32'd0);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h5555_AAAA;
    step();
    chk("t5_no_dvalid", 32'(bus.d_valid), 32'd0);
    bus.m_rvalid = 1'b0;
    step();

    // 6: stray responses in IDLE and in REQ
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h6666_0000;
    step();
    chk("t6_idle_ivalid", 32'(bus.i_valid), 32'd0);
    bus.m_rvalid = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_3000;
    step();
    bus.m_rvalid = 1'b1;
    step();
    chk("t6_req_hold", 32'(bus.m_req), 32'd1);
    chk("t6_req_ivalid", 32'(bus.i_valid), 32'd0);
    bus.m_rvalid = 1'b0;
    serve(0, 32'h6666_0001);
    chk("t6_irdata", bus.i_rdata, 32'h6666_0001);
    bus.i_req = 1'b0;
    step();

    // Random traffic with random bus latency and stray bus strobes
    for (int c = 0; c < 3000; c++) begin
      if (bus.i_req && bus.i_valid) begin
        if ($urandom_range(1, 0) == 0) bus.i_req = 1'b0;
        else bus.i_addr = $urandom;
      end else if (!bus.i_req && $urandom_range(2, 0) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = $urandom;
      end
      if ((bus.d_req && bus.d_valid) || (!bus.d_req && $urandom_range(2, 0) == 0)) begin
        if (bus.d_req && $urandom_range(1, 0) == 0) begin
          bus.d_req = 1'b0;
        end else begin
          bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(1, 0));
          bus.d_be = 4'($urandom_range(15, 0));
          bus.d_addr = $urandom; bus.d_wdata = $urandom;
        end
      end
      bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0;
      if (awaiting) begin
        if ($urandom_range(2, 0) == 0) begin
          bus.m_rvalid = 1'b1; bus.m_rdata = $urandom; awaiting = 1'b0;
        end else if ($urandom_range(7, 0) == 0) begin
          bus.m_gnt = 1'b1;
        end
      end else if (bus.m_req) begin
        if ($urandom_range(2, 0) == 0) begin
          bus.m_gnt = 1'b1; awaiting = 1'b1;
        end else if ($urandom_range(5, 0) == 0) begin
          bus.m_rvalid = 1'b1; bus.m_rdata = $urandom;
        end
      end else begin
        if ($urandom_range(7, 0) == 0) begin
          bus.m_rvalid = 1'b1; bus.m_rdata = $urandom;
        end
        if ($urandom_range(7, 0) == 0) bus.m_gnt = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
